// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: command-driven sequencer for a 4-bit combinational ALU.
//
// Takes register-level commands over a valid/ready channel, reads operands
// from an internal register file and presents them to an external ALU. It then
// captures the ALU result, writes it back, and returns it on a valid/ready
// response channel.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake
//   cmd_op            0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 LOADI,7 illegal
//   cmd_rd/rs1/rs2    destination / source register addresses
//   cmd_imm           immediate for LOADI
//   alu_a/b/sel       operands and select driven to the ALU (held between ops)
//   alu_result        combinational ALU result
//   alu_req           high for the single ISSUE cycle; qualifies alu_a/b/sel
//   rsp_valid/ready   response handshake
//   rsp_data          value written to rd (0 for an illegal opcode)
//   rsp_err           illegal opcode flag
//   rsp_zero          (ALU_SEQ_FLAGS_EN only) rsp_data==0 and rsp_err==0
//
// Optional feature macro: ALU_SEQ_FLAGS_EN adds the rsp_zero output.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_result,
  output logic          alu_req,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic          rsp_zero
`endif
);

  localparam int NREG = 2 ** AW;

  localparam logic [2:0] OP_SLT   = 3'd5;
  localparam logic [2:0] OP_LOADI = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [DW-1:0] rf_r [NREG];

  logic [DW-1:0] alu_a_r, alu_a_nxt_s;
  logic [DW-1:0] alu_b_r, alu_b_nxt_s;
  logic [2:0]    alu_sel_r, alu_sel_nxt_s;
  logic [AW-1:0] rd_r, rd_nxt_s;
  logic [DW-1:0] rsp_data_r, rsp_data_nxt_s;
  logic          rsp_err_r, rsp_err_nxt_s;
  logic          cmd_ready_r, rsp_valid_r, alu_req_r;

  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [DW-1:0] wr_data_s;

  logic accept_s;
  logic is_alu_op_s;

  // cmd_ready_r is high exactly in IDLE, so it doubles as the state qualifier.
  assign accept_s    = cmd_valid & cmd_ready_r;
  assign is_alu_op_s = (cmd_op <= OP_SLT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_alu_op_s) begin
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: operand latch, write-back and response data.
  always_comb begin
    alu_a_nxt_s    = alu_a_r;
    alu_b_nxt_s    = alu_b_r;
    alu_sel_nxt_s  = alu_sel_r;
    rd_nxt_s       = rd_r;
    rsp_data_nxt_s = rsp_data_r;
    rsp_err_nxt_s  = rsp_err_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = rd_r;
    wr_data_s      = alu_result;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_alu_op_s) begin
            // Operands are read before any write-back of this command.
            alu_a_nxt_s   = rf_r[cmd_rs1];
            alu_b_nxt_s   = rf_r[cmd_rs2];
            alu_sel_nxt_s = cmd_op;
            rd_nxt_s      = cmd_rd;
          end else if (cmd_op == OP_LOADI) begin
            wr_en_s        = 1'b1;
            wr_addr_s      = cmd_rd;
            wr_data_s      = cmd_imm;
            rsp_data_nxt_s = cmd_imm;
            rsp_err_nxt_s  = 1'b0;
          end else begin
            rsp_data_nxt_s = {DW{1'b0}};
            rsp_err_nxt_s  = 1'b1;
          end
        end else begin
          rd_nxt_s = rd_r;
        end
      end
      ST_ISSUE: begin
        wr_en_s        = 1'b1;
        wr_addr_s      = rd_r;
        wr_data_s      = alu_result;
        rsp_data_nxt_s = alu_result;
        rsp_err_nxt_s  = 1'b0;
      end
      ST_RESP: rsp_data_nxt_s = rsp_data_r;
      default: rsp_data_nxt_s = rsp_data_r;
    endcase
  end

  // Registered outputs; handshake flags are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r     <= {DW{1'b0}};
      alu_b_r     <= {DW{1'b0}};
      alu_sel_r   <= 3'd0;
      rd_r        <= {AW{1'b0}};
      rsp_data_r  <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      alu_req_r   <= 1'b0;
    end else begin
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      alu_sel_r   <= alu_sel_nxt_s;
      rd_r        <= rd_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      alu_req_r   <= (state_nxt_s == ST_ISSUE);
    end
  end

  // Register file with write-back port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= {DW{1'b0}};
      end
    end else if (wr_en_s) begin
      rf_r[wr_addr_s] <= wr_data_s;
    end else begin
      rf_r[wr_addr_s] <= rf_r[wr_addr_s];
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic rsp_zero_r;

  // Zero flag tracks rsp_data/rsp_err, so it is held exactly as they are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero_r <= 1'b0;
    end else begin
      rsp_zero_r <= (rsp_data_nxt_s == {DW{1'b0}}) && !rsp_err_nxt_s;
    end
  end

  assign rsp_zero = rsp_zero_r;
`endif

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign alu_req   = alu_req_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_sel   = alu_sel_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Command-driven initiator for the 4-bit combinational ALU. It is the requesting side of the ALU's a/b/sel→result interface.
- Accepts register-level ops over a valid/ready command channel and reads operands from a small internal register file.
- Drives the ALU operand/select ports, captures the ALU result, writes it back, and returns it on a valid/ready response channel.
- Sits between a host/test controller and the alu instance.

Parameters:
- DW, 4, datapath width; matches the ALU a/b/result width.
- AW, 2, register address width; register file depth NREG = 2**AW.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command ready
- cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 LOADI, 7 illegal
- cmd_rd  input  AW  destination register
- cmd_rs1  input  AW  source register A
- cmd_rs2  input  AW  source register B
- cmd_imm  input  DW  immediate for LOADI
- alu_a  output  DW  ALU operand a
- alu_b  output  DW  ALU operand b
- alu_sel  output  3  ALU select
- alu_result  input  DW  ALU combinational result
- alu_req  output  1  high during the ISSUE cycle only
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response ready
- rsp_data  output  DW  value written to rd (0 on error)
- rsp_err  output  1  illegal opcode flag

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE.
  - cmd_ready=1 once released.
  - alu_a, alu_b, alu_sel, alu_req, rsp_valid, rsp_data, rsp_err = 0.
  - All NREG registers = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1; a command is accepted on clk edge with cmd_valid&cmd_ready.
  - op 0..5: latch alu_a=rf[rs1], alu_b=rf[rs2], alu_sel=op, rd → ISSUE.
  - op 6 (LOADI): rf[rd]=cmd_imm, rsp_data=cmd_imm, rsp_err=0 → RESP. No ALU issue; alu_* hold.
  - op 7: rsp_data=0, rsp_err=1, no rf write → RESP.
- ISSUE:
  - Exactly one cycle; alu_req=1; alu_a/b/sel stable from registers.
  - At the end of the cycle: rf[rd]=alu_result, rsp_data=alu_result, rsp_err=0 → RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err held stable until rsp_valid&rsp_ready, then → IDLE.
  - cmd_ready=0 in ISSUE and RESP; cmd_valid is ignored.
- Latency, command accepted at edge N:
  - ALU op: ISSUE in cycle N+1, rsp_valid from edge N+2.
  - LOADI/illegal: rsp_valid from edge N+1.
  - Minimum spacing between accepts: 3 cycles (ALU op), 2 cycles (others), with rsp_ready held high.
- Hazards: rs1/rs2 equal to rd (or to each other) is legal. Operands are the pre-write values; write-back is visible to the next command.
- Arithmetic: all DW-bit. SUB and ADD wrap modulo 2**DW with no carry out. SLT produces 0 or 1 zero-extended; these are ALU properties and are passed through unchanged.
- ALU outputs: alu_a/b/sel hold their last issued values outside ISSUE. Only alu_req qualifies them.
- Reset mid-operation: any state returns to IDLE immediately.
  - In-flight command dropped; no response produced.
  - Register file cleared.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined: adds output port rsp_zero (1 bit).
  - rsp_zero = 1 when rsp_data==0 and rsp_err==0.
  - Registered with rsp_data and held with it; reset 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-cycle → immediately cmd_ready=1, rsp_valid=0, alu_a=alu_b=alu_sel=0. ADD r0=r0+r0 after release → rsp_data=0.
- LOADI r1=5, LOADI r2=3, then ADD r0=r1+r2 → ISSUE shows alu_a=5, alu_b=3, alu_sel=000, alu_req=1. rsp_valid 2 cycles after accept, rsp_data=8, rsp_err=0.
- SUB r3=r2-r1 (3-5) → rsp_data=4'hE. SLT r0=r2<r1 → rsp_data=1. XOR r0=r1^r1 → rsp_data=0 (rsp_zero=1 with ALU_SEQ_FLAGS_EN).
- op 7 with rd=r1 → rsp_err=1, rsp_data=0, 1 cycle after accept, no alu_req. A following ADD r0=r1+r0 shows alu_a=5 (r1 unchanged).
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_valid/rsp_data held stable, cmd_ready=0, no new accept. Accept occurs in the first IDLE cycle after the rsp handshake.
- Reset asserted during ISSUE of ADD r2=r1+r1 → no rsp_valid after release, and LOADI-free ADD r0=r1+r2 returns 0.
